// File: rtl/axi4_lite_master_write.sv
// AXI4-Lite single-beat write manager: AW/W issued together, then waits for B.
// Optional watchdog compiled in with `define AXI_MW_TIMEOUT_EN.
module axi4_lite_master_write #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        i_start_write,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_data,
  input  logic [AXI_DATA_WIDTH/8-1:0] i_strb,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_error,
  output logic                        o_timeout,
  output logic                        AW_VALID,
  output logic [2:0]                  AW_PROT,
  output logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
  input  logic                        AW_READY,
  output logic [AXI_DATA_WIDTH-1:0]   W_DATA,
  output logic                        W_VALID,
  output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
  input  logic                        W_READY,
  output logic                        B_READY,
  input  logic [1:0]                  B_RESP,
  input  logic                        B_VALID
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR_DATA,
    RESP,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic                        aw_valid_q, aw_valid_d;
  logic                        w_valid_q, w_valid_d;
  logic                        b_ready_q, b_ready_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0]   data_q, data_d;
  logic [AXI_DATA_WIDTH/8-1:0] strb_q, strb_d;
  logic                        aw_done, w_done;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      b_ready_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
    end else begin
      state_q    <= state_d;
      aw_valid_q <= aw_valid_d;
      w_valid_q  <= w_valid_d;
      b_ready_q  <= b_ready_d;
      done_q     <= done_d;
      error_q    <= error_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      strb_q     <= strb_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    aw_valid_d = aw_valid_q;
    w_valid_d  = w_valid_q;
    b_ready_d  = b_ready_q;
    done_d     = 1'b0;
    error_d    = error_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    // a channel counts as done once its VALID has dropped or handshakes now
    aw_done    = ~aw_valid_q | AW_READY;
    w_done     = ~w_valid_q | W_READY;
    unique case (state_q)
      IDLE: begin
        if (i_start_write) begin
          addr_d     = i_addr;
          data_d     = i_data;
          strb_d     = i_strb;
          aw_valid_d = 1'b1;
          w_valid_d  = 1'b1;
          error_d    = 1'b0;
          state_d    = ADDR_DATA;
        end
      end
      ADDR_DATA: begin
        if (AW_READY) aw_valid_d = 1'b0;
        if (W_READY)  w_valid_d  = 1'b0;
        if (aw_done && w_done) begin
          b_ready_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (B_VALID) begin
          b_ready_d = 1'b0;
          error_d   = B_RESP inside {2'b10, 2'b11};
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AXI_MW_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // counter saturates; the transaction itself is never aborted
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (state_q == IDLE) begin
      if (i_start_write) begin
        cnt_d     = '0;
        timeout_d = 1'b0;
      end
    end else if (state_q == ADDR_DATA || state_q == RESP) begin
      if (cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == TMAX) timeout_d = 1'b1;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_busy   = (state_q != IDLE);
  assign o_done   = done_q;
  assign o_error  = error_q;
  assign AW_VALID = aw_valid_q;
  assign AW_PROT  = 3'b000;
  assign AW_ADDR  = addr_q;
  assign W_DATA   = data_q;
  assign W_VALID  = w_valid_q;
  assign W_STRB   = strb_q;
  assign B_READY  = b_ready_q;

endmodule

// File: tb/tb_axi4_lite_master_write.sv
// Directed bench for axi4_lite_master_write.
// Define AXI_MW_TIMEOUT_EN for both files to exercise the watchdog.
module tb_axi4_lite_master_write;
  localparam int AW = 64;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          i_start_write = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [DW-1:0] i_data = '0;
  logic [3:0]    i_strb = '0;
  logic          o_busy, o_done, o_error, o_timeout;
  logic          AW_VALID, W_VALID, B_READY;
  logic [2:0]    AW_PROT;
  logic [AW-1:0] AW_ADDR;
  logic [DW-1:0] W_DATA;
  logic [3:0]    W_STRB;
  logic          AW_READY = 1'b0;
  logic          W_READY = 1'b0;
  logic [1:0]    B_RESP = 2'b00;
  logic          B_VALID = 1'b0;

  int checks = 0;
  int failures = 0;

`ifdef AXI_MW_TIMEOUT_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  axi4_lite_master_write #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .arst(arst),
    .i_start_write(i_start_write),
    .i_addr(i_addr), .i_data(i_data), .i_strb(i_strb),
    .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error), .o_timeout(o_timeout),
    .AW_VALID(AW_VALID), .AW_PROT(AW_PROT),
    .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .W_VALID(W_VALID),
    .W_STRB(W_STRB), .W_READY(W_READY),
    .B_READY(B_READY), .B_RESP(B_RESP),
    .B_VALID(B_VALID)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({AW_VALID, W_VALID, B_READY, o_busy, o_done, o_error, o_timeout} !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b exp 0000000",
               {AW_VALID, W_VALID, B_READY, o_busy, o_done, o_error, o_timeout});
    end
    checks++;
    if (AW_ADDR !== '0 || W_DATA !== '0 || W_STRB !== '0 || AW_PROT !== 3'b0) begin
      failures++;
      $display("FAIL reset_data: addr %h data %h strb %h prot %b exp 0", AW_ADDR, W_DATA, W_STRB, AW_PROT);
    end
    tick();
    arst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    AW_READY = 1'b1; W_READY = 1'b1;
    i_addr = 64'h1000; i_data = 32'hDEADBEEF; i_strb = 4'hF;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    checks++;
    if (!(AW_VALID === 1'b1 && W_VALID === 1'b1 && o_busy === 1'b1 && B_READY === 1'b0)) begin
      failures++;
      $display("FAIL nom_valid: aw %b w %b busy %b bready %b exp 1 1 1 0", AW_VALID, W_VALID, o_busy, B_READY);
    end
    checks++;
    if (AW_ADDR !== 64'h1000 || W_DATA !== 32'hDEADBEEF || W_STRB !== 4'hF) begin
      failures++;
      $display("FAIL nom_payload: addr %h data %h strb %h exp 1000 deadbeef f", AW_ADDR, W_DATA, W_STRB);
    end
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    checks++;
    if (!(AW_VALID === 1'b0 && W_VALID === 1'b0 && B_READY === 1'b1)) begin
      failures++;
      $display("FAIL nom_resp: aw %b w %b bready %b exp 0 0 1", AW_VALID, W_VALID, B_READY);
    end
    tick();
    tick();
    B_VALID = 1'b1; B_RESP = 2'b00;
    tick();
    B_VALID = 1'b0;
    checks++;
    if (!(o_done === 1'b1 && o_error === 1'b0 && B_READY === 1'b0 && o_busy === 1'b1)) begin
      failures++;
      $display("FAIL nom_done: done %b err %b bready %b busy %b exp 1 0 0 1", o_done, o_error, B_READY, o_busy);
    end
    tick();
    checks++;
    if (!(o_done === 1'b0 && o_busy === 1'b0)) begin
      failures++;
      $display("FAIL nom_idle: done %b busy %b exp 0 0", o_done, o_busy);
    end
  endtask

  task automatic test_skew(input bit aw_slow);
    AW_READY = !aw_slow; W_READY = aw_slow;
    i_addr = 64'h0000_00AB_0000_4440; i_data = 32'h1234_5678; i_strb = 4'h5;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ((aw_slow ? AW_VALID : W_VALID) !== 1'b1 ||
          (aw_slow ? W_VALID : AW_VALID) !== (i == 0) ||
          B_READY !== 1'b0 || AW_ADDR !== 64'h0000_00AB_0000_4440 ||
          W_DATA !== 32'h1234_5678) begin
        failures++;
        $display("FAIL skew%0d_c%0d: aw %b w %b bready %b addr %h data %h", aw_slow, i,
                 AW_VALID, W_VALID, B_READY, AW_ADDR, W_DATA);
      end
      tick();
    end
    if (aw_slow) AW_READY = 1'b1; else W_READY = 1'b1;
    checks++;
    if ((aw_slow ? AW_VALID : W_VALID) !== 1'b1 || B_READY !== 1'b0) begin
      failures++;
      $display("FAIL skew%0d_last: aw %b w %b bready %b exp slow=1 bready=0", aw_slow, AW_VALID, W_VALID, B_READY);
    end
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    checks++;
    if (!(AW_VALID === 1'b0 && W_VALID === 1'b0 && B_READY === 1'b1)) begin
      failures++;
      $display("FAIL skew%0d_resp: aw %b w %b bready %b exp 0 0 1", aw_slow, AW_VALID, W_VALID, B_READY);
    end
    B_VALID = 1'b1; B_RESP = 2'b01;
    tick();
    B_VALID = 1'b0;
    checks++;
    if (!(o_done === 1'b1 && o_error === 1'b0)) begin
      failures++;
      $display("FAIL skew%0d_done: done %b err %b exp 1 0", aw_slow, o_done, o_error);
    end
    tick();
  endtask

  task automatic test_error();
    AW_READY = 1'b1; W_READY = 1'b1;
    i_addr = 64'h5000; i_data = 32'hCAFE0001; i_strb = 4'h3;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    B_VALID = 1'b1; B_RESP = 2'b10;
    tick();
    B_VALID = 1'b0; B_RESP = 2'b00;
    checks++;
    if (!(o_done === 1'b1 && o_error === 1'b1)) begin
      failures++;
      $display("FAIL err_done: done %b err %b exp 1 1", o_done, o_error);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (!(o_error === 1'b1 && o_busy === 1'b0)) begin
      failures++;
      $display("FAIL err_hold: err %b busy %b exp 1 0", o_error, o_busy);
    end
    AW_READY = 1'b1; W_READY = 1'b1;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    checks++;
    if (o_error !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: err %b exp 0", o_error);
    end
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    B_VALID = 1'b1; B_RESP = 2'b11;
    tick();
    B_VALID = 1'b0; B_RESP = 2'b00;
    checks++;
    if (!(o_done === 1'b1 && o_error === 1'b1)) begin
      failures++;
      $display("FAIL err_decerr: done %b err %b exp 1 1", o_done, o_error);
    end
    tick();
    AW_READY = 1'b1; W_READY = 1'b1;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    B_VALID = 1'b1;
    tick();
    B_VALID = 1'b0;
    checks++;
    if (!(o_done === 1'b1 && o_error === 1'b0)) begin
      failures++;
      $display("FAIL err_okay: done %b err %b exp 1 0", o_done, o_error);
    end
    tick();
  endtask

  task automatic test_start_while_busy();
    int n = 0;
    AW_READY = 1'b0; W_READY = 1'b0;
    i_addr = 64'h3000; i_data = 32'h0000_0001; i_strb = 4'h1;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    B_VALID = 1'b1;
    i_addr = 64'h2000; i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    B_VALID = 1'b0;
    checks++;
    if (AW_ADDR !== 64'h3000 || AW_VALID !== 1'b1 || B_READY !== 1'b0) begin
      failures++;
      $display("FAIL busy_ad: addr %h aw %b bready %b exp 3000 1 0", AW_ADDR, AW_VALID, B_READY);
    end
    AW_READY = 1'b1; W_READY = 1'b1;
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    checks++;
    if (AW_ADDR !== 64'h3000 || AW_VALID !== 1'b0 || B_READY !== 1'b1) begin
      failures++;
      $display("FAIL busy_resp: addr %h aw %b bready %b exp 3000 0 1", AW_ADDR, AW_VALID, B_READY);
    end
    B_VALID = 1'b1;
    tick();
    B_VALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (o_done === 1'b1) n++;
      tick();
    end
    checks++;
    if (n != 1 || o_busy !== 1'b0 || AW_VALID !== 1'b0) begin
      failures++;
      $display("FAIL busy_once: dones %0d busy %b aw %b exp 1 0 0", n, o_busy, AW_VALID);
    end
  endtask

  task automatic test_reset_mid();
    AW_READY = 1'b1; W_READY = 1'b1;
    i_addr = 64'h7000; i_data = 32'hA5A5_A5A5; i_strb = 4'hC;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    arst = 1'b1;
    #1;
    checks++;
    if ({AW_VALID, W_VALID, B_READY, o_busy, o_done, o_error, o_timeout} !== 7'b0 ||
        AW_ADDR !== '0 || W_DATA !== '0 || W_STRB !== '0) begin
      failures++;
      $display("FAIL rst_mid: ctl %b addr %h data %h strb %h exp all 0",
               {AW_VALID, W_VALID, B_READY, o_busy, o_done, o_error, o_timeout}, AW_ADDR, W_DATA, W_STRB);
    end
    tick();
    arst = 1'b0;
    tick();
    AW_READY = 1'b1; W_READY = 1'b1;
    i_addr = 64'h1000; i_data = 32'hDEADBEEF; i_strb = 4'hF;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    checks++;
    if (AW_ADDR !== 64'h1000 || W_DATA !== 32'hDEADBEEF || AW_VALID !== 1'b1) begin
      failures++;
      $display("FAIL rst_after: addr %h data %h aw %b exp 1000 deadbeef 1", AW_ADDR, W_DATA, AW_VALID);
    end
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    B_VALID = 1'b1;
    tick();
    B_VALID = 1'b0;
    checks++;
    if (!(o_done === 1'b1 && o_error === 1'b0)) begin
      failures++;
      $display("FAIL rst_done: done %b err %b exp 1 0", o_done, o_error);
    end
    tick();
  endtask

  task automatic test_watchdog();
    AW_READY = 1'b1; W_READY = 1'b1;
    i_addr = 64'h9000; i_data = 32'h0BAD_F00D; i_strb = 4'hF;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_early: timeout %b exp 0", o_timeout);
    end
    tick();
    checks++;
    if (o_timeout !== WD || B_READY !== 1'b1) begin
      failures++;
      $display("FAIL wd_rise: timeout %b bready %b exp %b 1", o_timeout, B_READY, WD);
    end
    for (int i = 0; i < 3; i++) tick();
    B_VALID = 1'b1;
    tick();
    B_VALID = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_timeout !== WD) begin
      failures++;
      $display("FAIL wd_done: done %b timeout %b exp 1 %b", o_done, o_timeout, WD);
    end
    tick();
    AW_READY = 1'b1; W_READY = 1'b1;
    i_start_write = 1'b1;
    tick();
    i_start_write = 1'b0;
    checks++;
    if (o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_clear: timeout %b exp 0", o_timeout);
    end
    tick();
    AW_READY = 1'b0; W_READY = 1'b0;
    B_VALID = 1'b1;
    tick();
    B_VALID = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_timeout !== 1'b0) begin
      failures++;
      $display("FAIL wd_short: done %b timeout %b exp 1 0", o_done, o_timeout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_skew(1'b1);
    test_skew(1'b0);
    test_error();
    test_start_while_busy();
    test_reset_mid();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master_write.md
Name: axi4_lite_master_write

Overview:
AXI4-Lite write initiator. It is the manager-side counterpart to the memory-side write slave.
- Accepts a single-beat write request (address, data, strobes) from the cache/memory-controller side.
- Drives the AW and W channels concurrently, waits for the B response, and reports completion and error status back to the requester.
- One outstanding transaction at a time.

Parameters:
- AXI_ADDR_WIDTH, 64, address width.
- AXI_DATA_WIDTH, 32, data width; strobe width is AXI_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, watchdog threshold in clock cycles. Used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- arst  in  1  asynchronous active-high reset.
- i_start_write  in  1  request pulse/level; sampled only in IDLE.
- i_addr  in  AXI_ADDR_WIDTH  write address.
- i_data  in  AXI_DATA_WIDTH  write data.
- i_strb  in  AXI_DATA_WIDTH/8  byte strobes.
- o_busy  out  1  transaction in flight (state != IDLE).
- o_done  out  1  one-cycle completion pulse.
- o_error  out  1  last response was SLVERR/DECERR.
- o_timeout  out  1  watchdog flag; tied 0 without the macro.
- AW_VALID  out  1  write-address valid.
- AW_PROT  out  3  constant 3'b000.
- AW_ADDR  out  AXI_ADDR_WIDTH  latched address.
- AW_READY  in  1  write-address ready.
- W_DATA  out  AXI_DATA_WIDTH  latched data.
- W_VALID  out  1  write-data valid.
- W_STRB  out  AXI_DATA_WIDTH/8  latched strobes.
- W_READY  in  1  write-data ready.
- B_READY  out  1  response ready.
- B_RESP  in  2  write response code.
- B_VALID  in  1  response valid.

Behaviour:
Reset:
- arst forces state IDLE asynchronously, at any point including mid-transaction.
- All outputs go to 0: AW_VALID, W_VALID, B_READY, o_busy, o_done, o_error, o_timeout, AW_ADDR, W_DATA, W_STRB.

State machine: IDLE -> ADDR_DATA -> RESP -> DONE -> IDLE. All outputs are registered.

IDLE:
- On i_start_write=1, latch i_addr, i_data and i_strb into AW_ADDR, W_DATA and W_STRB.
- Set AW_VALID=1 and W_VALID=1 on the next edge; clear o_error and o_timeout; go to ADDR_DATA.
- Latency: VALIDs are high one cycle after start is sampled.

ADDR_DATA:
- AW and W are tracked independently with aw_done and w_done flags.
- AW_VALID stays high until a cycle where AW_READY=1; it deasserts on the following edge. The same rule applies to W_VALID and W_READY.
- A handshake in the first VALID cycle is legal (one-cycle VALID).
- The two handshakes may complete in the same cycle or in either order.
- When both are complete, go to RESP and assert B_READY=1 on that same edge.
- AW_ADDR, W_DATA and W_STRB stay stable while their VALID is high.
- VALID is never withdrawn before its handshake, and VALID assertion never waits on READY.

RESP:
- B_READY=1. B_VALID seen earlier, while B_READY=0, is not accepted.
- On B_VALID=1: set B_READY=0 and o_error=B_RESP[1] (2'b10/2'b11 are errors; 2'b00/2'b01 are not), and go to DONE.

DONE:
- o_done=1 for exactly one cycle, o_busy=1, then IDLE.
- o_error holds until the next accepted start.

General:
- i_start_write is ignored in every state except IDLE. Back-to-back requests are accepted in the IDLE cycle after DONE.

Optional Feature:
Macro AXI_MW_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on leaving IDLE and increments each cycle in ADDR_DATA and RESP.
  - When the counter reaches TIMEOUT_CYCLES, o_timeout goes high and stays high (sticky) until the next accepted start or reset.
  - The transaction is NOT aborted; handshakes continue normally and the counter saturates.
- Undefined: no counter is synthesized and o_timeout is constant 0.

Test Plan:
1. Nominal write: start with addr 0x1000, data 0xDEADBEEF, strb 0xF; AW_READY=W_READY=1; B_VALID with OKAY two cycles after B_READY rises. Required: both VALIDs high for exactly 1 cycle; AW_ADDR=0x1000; W_DATA=0xDEADBEEF; one o_done pulse; o_error=0; o_busy low after DONE.
2. Skewed handshakes: W_READY=1 immediately, AW_READY held low for 5 cycles. Required: W_VALID drops after 1 cycle; AW_VALID high for 6 cycles with AW_ADDR stable; B_READY rises only after the AW handshake. Repeat with the skew reversed.
3. Error response: B_RESP=2'b10. Required: o_error=1 together with o_done; it stays 1 until the next start. Then an OKAY transaction clears it.
4. Start while busy: pulse i_start_write with addr 0x2000 during ADDR_DATA and during RESP. Required: the request is ignored; AW_ADDR stays at the original value; exactly one o_done.
5. Reset mid-RESP: assert arst while B_READY=1. Required: all outputs 0 immediately. A subsequent nominal write completes correctly.
6. Watchdog: with AXI_MW_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold B_VALID for 20 cycles. Required: o_timeout rises at cycle 16 after leaving IDLE; the transaction then completes with o_done; o_timeout clears on the next start. Without the macro, o_timeout stays 0.
